// File: rtl/dmem_arbiter_if.sv
// Two-master data-memory arbitration bus: both master request/response ports plus the
// single-ported memory side. The arbiter takes the slave view.
interface dmem_arbiter_if;
  logic        m0_req,   m1_req;
  logic        m0_we,    m1_we;
  logic [3:0]  m0_sel,   m1_sel;
  logic [31:0] m0_addr,  m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_lock,  m1_lock;
  logic        m0_gnt,   m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd_req_o;
  logic [31:0] mem_rd_addr_o;
  logic [31:0] mem_rd_data_i;
  logic        mem_wr_req_o;
  logic [3:0]  mem_wr_sel_o;
  logic [31:0] mem_wr_addr_o, mem_wr_data_o;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_sel, m1_sel, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_lock, m1_lock, mem_rd_data_i,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           mem_rd_req_o, mem_rd_addr_o, mem_wr_req_o, mem_wr_sel_o,
           mem_wr_addr_o, mem_wr_data_o
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_sel, m1_sel, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_lock, m1_lock, mem_rd_data_i,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           mem_rd_req_o, mem_rd_addr_o, mem_wr_req_o, mem_wr_sel_o,
           mem_wr_addr_o, mem_wr_data_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Core/debug data-memory arbiter: round-robin on ties, optional bus lock with a
// timeout that forces release and raises a sticky lock_err.
module dmem_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic          lock_err
);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t            r_state;
  logic              r_rr_last;
  logic [CW-1:0]     r_lock_cnt;
  logic              r_lock_err;
  logic              r_rvalid [2];
  logic [31:0]       r_rdata  [2];

  logic [1:0]        w_req, w_we, w_lock, w_gnt;
  logic [1:0][3:0]   w_sel;
  logic [1:0][31:0]  w_addr, w_wdata;
  logic              w_idx, w_any, w_rd, w_wr;

  assign w_req   = {bus.m1_req,   bus.m0_req};
  assign w_we    = {bus.m1_we,    bus.m0_we};
  assign w_lock  = {bus.m1_lock,  bus.m0_lock};
  assign w_sel   = {bus.m1_sel,   bus.m0_sel};
  assign w_addr  = {bus.m1_addr,  bus.m0_addr};
  assign w_wdata = {bus.m1_wdata, bus.m0_wdata};

  // Grant is combinational; a tie goes to whichever master was not granted last.
  always_comb begin
    w_gnt = '0;
    if (!rst) begin
      case (r_state)
        IDLE:    w_gnt = (w_req == 2'b11) ? (r_rr_last ? 2'b01 : 2'b10) : w_req;
        LOCK0:   w_gnt = {1'b0, w_req[0]};
        LOCK1:   w_gnt = {w_req[1], 1'b0};
        default: w_gnt = '0;
      endcase
    end
  end

  assign w_idx = w_gnt[1];
  assign w_any = |w_gnt;
  assign w_rd  = w_any & ~w_we[w_idx];
  assign w_wr  = w_any &  w_we[w_idx];

  assign bus.m0_gnt        = w_gnt[0];
  assign bus.m1_gnt        = w_gnt[1];
  assign bus.mem_rd_req_o  = w_rd;
  assign bus.mem_rd_addr_o = w_rd ? w_addr[w_idx]  : '0;
  assign bus.mem_wr_req_o  = w_wr;
  assign bus.mem_wr_sel_o  = w_wr ? w_sel[w_idx]   : '0;
  assign bus.mem_wr_addr_o = w_wr ? w_addr[w_idx]  : '0;
  assign bus.mem_wr_data_o = w_wr ? w_wdata[w_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_last  <= 1'b1;
      r_lock_cnt <= '0;
      r_lock_err <= 1'b0;
    end else begin
      if (w_any) r_rr_last <= w_idx;
      case (r_state)
        IDLE: begin
          if (w_any && w_lock[w_idx]) begin
            r_state    <= w_idx ? LOCK1 : LOCK0;
            r_lock_cnt <= '0;
          end
        end
        LOCK0, LOCK1: begin
          // Timeout wins over a still-asserted lock.
          if (r_lock_cnt == CW'(LOCK_MAX)) begin
            r_state    <= IDLE;
            r_lock_err <= 1'b1;
          end else if (!w_lock[r_state == LOCK1]) begin
            r_state <= IDLE;
          end
          r_lock_cnt <= r_lock_cnt + CW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_rvalid[i] <= 1'b0;
        r_rdata[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_rvalid[i] <= w_gnt[i] & ~w_we[i];
        if (w_gnt[i] && !w_we[i]) r_rdata[i] <= bus.mem_rd_data_i;
      end
    end
  end

  assign bus.m0_rvalid = r_rvalid[0];
  assign bus.m1_rvalid = r_rvalid[1];
  assign bus.m0_rdata  = r_rdata[0];
  assign bus.m1_rdata  = r_rdata[1];
  assign lock_err      = r_lock_err;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scenarios then random traffic, all checked cycle by cycle against a
// behavioural ownership/round-robin model of the arbiter.
module tb_dmem_arbiter;
  localparam int LOCK_MAX = 4;

  typedef struct {
    logic        req, we, lock;
    logic [3:0]  sel;
    logic [31:0] addr, wdata;
  } mreq_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lock_err;

  dmem_arbiter_if bus ();
  dmem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (.clk(clk), .rst(rst), .bus(bus), .lock_err(lock_err));

  always #5 clk = ~clk;
  assign bus.mem_rd_data_i = bus.mem_rd_addr_o ^ 32'hC0DE_5A5A;

  int checks = 0, failures = 0;

  // model: owner -1 = nobody; held = cycles already spent owning
  int          owner = -1, held = 0, last = 1;
  logic        err = 1'b0;
  logic        rv [2];
  logic [31:0] rd [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic mreq_t mk(logic req, logic we, logic lock, logic [3:0] sel,
                               logic [31:0] addr, logic [31:0] wdata);
    mreq_t m;
    m.req = req; m.we = we; m.lock = lock; m.sel = sel; m.addr = addr; m.wdata = wdata;
    return m;
  endfunction

  function automatic mreq_t rnd();
    return mk($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
              4'($urandom), $urandom, $urandom);
  endfunction

  task automatic model_reset();
    owner = -1; held = 0; last = 1; err = 1'b0;
    rv[0] = 1'b0; rv[1] = 1'b0; rd[0] = '0; rd[1] = '0;
  endtask

  task automatic step(input logic r, input mreq_t a, input mreq_t b);
    mreq_t m [2];
    int g;
    logic erd, ewr;
    m[0] = a; m[1] = b;
    @(posedge clk); #1;
    rst = r;
    bus.m0_req = a.req; bus.m0_we = a.we; bus.m0_lock = a.lock; bus.m0_sel = a.sel;
    bus.m0_addr = a.addr; bus.m0_wdata = a.wdata;
    bus.m1_req = b.req; bus.m1_we = b.we; bus.m1_lock = b.lock; bus.m1_sel = b.sel;
    bus.m1_addr = b.addr; bus.m1_wdata = b.wdata;
    if (r) model_reset();
    #2;
    g = -1;
    if (!r) begin
      if (owner < 0) begin
        if (a.req && b.req) g = (last == 0) ? 1 : 0;
        else if (a.req)     g = 0;
        else if (b.req)     g = 1;
      end else if (m[owner].req) g = owner;
    end
    erd = (g >= 0) && !m[g].we;
    ewr = (g >= 0) &&  m[g].we;
    chk("gnt",      {30'd0, bus.m1_gnt, bus.m0_gnt}, {30'd0, g == 1, g == 0});
    chk("rd_req",   32'(bus.mem_rd_req_o), 32'(erd));
    chk("rd_addr",  bus.mem_rd_addr_o, erd ? m[g].addr : 32'd0);
    chk("wr_req",   32'(bus.mem_wr_req_o), 32'(ewr));
    chk("wr_sel",   32'(bus.mem_wr_sel_o), ewr ? 32'(m[g].sel) : 32'd0);
    chk("wr_addr",  bus.mem_wr_addr_o, ewr ? m[g].addr : 32'd0);
    chk("wr_data",  bus.mem_wr_data_o, ewr ? m[g].wdata : 32'd0);
    chk("rvalid0",  32'(bus.m0_rvalid), 32'(rv[0]));
    chk("rvalid1",  32'(bus.m1_rvalid), 32'(rv[1]));
    chk("rdata0",   bus.m0_rdata, rd[0]);
    chk("rdata1",   bus.m1_rdata, rd[1]);
    chk("lock_err", 32'(lock_err), 32'(err));
    // advance the model to the state after the coming edge
    if (r) model_reset();
    else begin
      rv[0] = 1'b0; rv[1] = 1'b0;
      if (erd) begin rv[g] = 1'b1; rd[g] = m[g].addr ^ 32'hC0DE_5A5A; end
      if (owner < 0) begin
        if (g >= 0 && m[g].lock) begin owner = g; held = 0; end
      end else if (held == LOCK_MAX) begin
        owner = -1; err = 1'b1;
      end else if (!m[owner].lock) owner = -1;
      else held++;
      if (g >= 0) last = g;
    end
  endtask

  initial begin
    mreq_t idle, rd0, rd1, wr1, lk0, lk1, rq0, rq1;
    idle = mk(0, 0, 0, 4'h0, 32'h0, 32'h0);
    rd0  = mk(1, 0, 0, 4'hF, 32'h0000_0040, 32'hFFFF_FFFF);
    rd1  = mk(1, 0, 0, 4'hF, 32'h0000_0080, 32'hEEEE_EEEE);
    wr1  = mk(1, 1, 0, 4'b0011, 32'h0000_0100, 32'hA5A5_1234);
    lk0  = mk(1, 1, 1, 4'hF, 32'h0000_0200, 32'h1111_2222);
    lk1  = mk(1, 0, 1, 4'hF, 32'h0000_0300, 32'h0);
    rq0  = mk(1, 0, 0, 4'hF, 32'h0000_0400, 32'h0);
    rq1  = mk(1, 0, 0, 4'hF, 32'h0000_0500, 32'h0);
    model_reset();
    step(1, idle, idle);
    step(1, idle, idle);

    // tie right after reset: m0 first, then m1, read data back to back
    step(0, rd0, rd1);
    chk("tie_m0_first", 32'(bus.m0_gnt), 32'd1);
    step(0, idle, rd1);
    chk("tie_m1_next", 32'(bus.m1_gnt), 32'd1);
    step(0, idle, idle);
    chk("tie_rdata1", bus.m1_rdata, 32'h0000_0080 ^ 32'hC0DE_5A5A);

    // m1 write lands on the memory port in the same cycle
    step(0, idle, wr1);
    chk("wr_addr_100", bus.mem_wr_addr_o, 32'h0000_0100);
    chk("wr_data_a5", bus.mem_wr_data_o, 32'hA5A5_1234);
    step(0, idle, idle);
    chk("wr_no_rvalid", 32'(bus.m1_rvalid), 32'd0);

    // m1 holds the bus for three accesses while m0 keeps asking
    step(0, idle, lk1);
    repeat (2) step(0, rq0, lk1);
    step(0, rq0, idle);
    chk("lock_m0_blocked", 32'(bus.m0_gnt), 32'd0);
    step(0, rq0, idle);
    chk("lock_m0_after", 32'(bus.m0_gnt), 32'd1);

    // m0 overstays its lock: forced release, m1 wins the next arbitration
    step(0, lk0, idle);
    repeat (LOCK_MAX + 1) step(0, lk0, rq1);
    step(0, rq0, rq1);
    chk("timeout_err", 32'(lock_err), 32'd1);
    chk("timeout_m1", 32'(bus.m1_gnt), 32'd1);

    // reset the cycle after a read grant kills the rvalid and lock_err
    step(0, rd0, idle);
    step(1, idle, idle);
    chk("rst_rvalid", 32'(bus.m0_rvalid), 32'd0);
    chk("rst_lock_err", 32'(lock_err), 32'd0);
    step(0, idle, idle);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) == 0, rnd(), rnd());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 16: max cycles one master may hold a lock before forced release.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 m0_req, m1_req  input  1 each  access request; m0 is the core, m1 is the debug/DMA master.
REQ-005 m0_we, m1_we  input  1 each  1 = write, 0 = read.
REQ-006 m0_sel, m1_sel  input  4 each  byte-lane write enables, used for writes only.
REQ-007 m0_addr, m1_addr  input  32 each  byte address.
REQ-008 m0_wdata, m1_wdata  input  32 each  write data.
REQ-009 m0_lock, m1_lock  input  1 each  request to keep ownership after the current access.
REQ-010 m0_gnt, m1_gnt  output  1 each  access accepted this cycle (combinational).
REQ-011 m0_rvalid, m1_rvalid  output  1 each  registered read-data-valid pulse.
REQ-012 m0_rdata, m1_rdata  output  32 each  registered read data.
REQ-013 mem_rd_req_o  output  1  memory read strobe.
REQ-014 mem_rd_addr_o  output  32  memory read address.
REQ-015 mem_rd_data_i  input  32  memory read data, combinational in the same cycle as mem_rd_req_o.
REQ-016 mem_wr_req_o  output  1  memory write strobe.
REQ-017 mem_wr_sel_o  output  4  memory byte-lane enables.
REQ-018 mem_wr_addr_o, mem_wr_data_o  output  32 each  memory write address and data.
REQ-019 lock_err  output  1  sticky flag, set on forced lock release.

Function
REQ-020 States: IDLE (no owner), LOCK0 (m0 owns), LOCK1 (m1 owns); a 1-bit rr_last register records the last granted master.
REQ-021 In IDLE, a single requester is granted in the same cycle it requests; at most one gnt is high in any cycle.
REQ-022 In IDLE with both requesting, the master other than rr_last is granted; rr_last is updated to the granted master on every grant.
REQ-023 In LOCKn, only master n can be granted; the other master's gnt stays 0 regardless of its req.
REQ-024 A granted access with lock=1 moves IDLE->LOCKn, or holds LOCKn, on the next edge.
REQ-025 In LOCKn, a cycle with m<n>_lock=0 (with or without req) returns to IDLE on the next edge.
REQ-026 A lock counter clears on entry to LOCKn and increments each cycle in LOCKn.
REQ-027 When the lock counter reaches LOCK_MAX, the FSM returns to IDLE on the next edge and sets lock_err; lock_err is cleared only by rst.
REQ-028 On the grant cycle, the granted master's fields drive the memory port combinationally; for a write: mem_wr_req_o=1, mem_wr_sel_o=sel, mem_wr_addr_o=addr, mem_wr_data_o=wdata.
REQ-029 For a granted read: mem_rd_req_o=1 and mem_rd_addr_o=addr; mem_rd_data_i is captured into mn_rdata, and mn_rvalid pulses high exactly one cycle after gnt.
REQ-030 mn_rdata holds its value until the next read for that master; rvalid is never asserted for writes.
REQ-031 With no grant in a cycle, all mem_* outputs are 0.
REQ-032 Back-to-back accesses are supported: one access per cycle, no bubble.

Reset
REQ-033 While rst=1: state=IDLE, rr_last=1 (m0 wins the first tie), lock counter=0, lock_err=0, all rvalid/rdata=0, all gnt and mem_* outputs forced to 0.
REQ-034 Reset asserted mid-lock or mid-read drops ownership and suppresses the pending rvalid; after release, the first edge behaves as IDLE.

Verification
REQ-035 Tie: both read in the same cycle after reset -> m0_gnt; next cycle m1_gnt; m0_rvalid then m1_rvalid on consecutive cycles with the correct data.
REQ-036 Write path: m1 write, addr=0x100, sel=4'b0011, wdata=0xA5A5_1234 -> same cycle mem_wr_req_o=1 with these values, no rvalid.
REQ-037 Lock: m1 holds lock for 3 accesses while m0 requests continuously -> m0_gnt=0 for those 3 cycles, then m0 is granted the cycle after m1_lock drops.
REQ-038 Timeout: m0 holds lock with LOCK_MAX=4 while m1 requests -> forced IDLE, lock_err=1, m1 granted on the next arbitration.
REQ-039 Reset mid-read: rst pulsed the cycle after m0_gnt on a read -> m0_rvalid stays 0, all outputs 0, lock_err 0.
